alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue stage that drives the 32-bit ALU: decodes RV32I OP, OP-IMM, LUI and AUIPC instructions into ALU operands a, b and the 4-bit aluop code.
- Sits between register read and execute, with valid/ready handshakes on both sides.
- Output is fully registered through a 2-entry skid buffer, so in_ready has no combinational path from out_ready.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
flush  input  1  synchronous discard of all buffered entries.
in_valid  input  1  upstream holds a valid instruction.
in_ready  output  1  stage can accept; registered.
in_instr  input  32  instruction word.
in_pc  input  32  instruction address.
in_rs1  input  32  rs1 register value.
in_rs2  input  32  rs2 register value.
out_valid  output  1  output entry valid.
out_ready  input  1  ALU/execute accepts the entry.
out_a  output  32  ALU operand a.
out_b  output  32  ALU operand b.
out_aluop  output  4  ALU op code.
out_rd  output  5  destination register, instr[11:7].
out_illegal  output  1  entry is an unsupported or illegal encoding.

Behaviour:
- Reset is synchronous, active-high, on clk. On reset: out_valid=0, in_ready=1, out_a/out_b=0, out_aluop=0, out_rd=0, out_illegal=0, both buffer entries empty.
- Reset mid-transfer drops every buffered entry. flush does the same, except data registers are not cleared.
- aluop encoding is {bit3, funct3}:
  - 0 add, 8 sub, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 13 sra, 6 or, 7 and.
  - No other value is ever emitted.
- Decode by opcode = instr[6:0]:
  - OP (0110011): a=rs1, b=rs2, aluop={instr[30],funct3}.
    - Legal funct7: 0000000 for any funct3.
    - Also legal: 0100000 with funct3 000 or 101.
    - Everything else is illegal.
  - OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20].
    - For funct3 000,010,011,100,110,111: aluop={0,funct3}, and instr[30] is ignored, so ADDI is never sub.
    - For funct3 001 (shift left): b={27'b0, instr[24:20]}. instr[31:25] must be 0000000, else illegal. aluop=1.
    - For funct3 101 (shift right): b={27'b0, instr[24:20]}. instr[31:25] must be 0000000 (srli, aluop=5) or 0100000 (srai, aluop=13), else illegal.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, aluop=0.
  - AUIPC (0010111): a=pc, b={instr[31:12],12'b0}, aluop=0.
  - Any other opcode is illegal.
- An illegal entry still transfers, with out_illegal=1, out_a=0, out_b=0, out_aluop=0 and out_rd=instr[11:7].
- Handshake:
  - A transfer happens on a clk edge where valid&&ready.
  - Once out_valid is asserted, out_* stay stable until accepted.
  - in_ready=1 iff the skid entry is empty.
- Latency: an accepted instruction appears on out_* at the next edge when the main entry is empty or being drained that same cycle.
- Skid behaviour:
  - If the main entry is full and not accepted while an input is accepted, the decoded input goes to the skid entry and in_ready drops next cycle.
  - When main drains, skid moves to main and in_ready rises next cycle.
  - Order is strictly FIFO.
- Simultaneous in accept and out accept with only the main entry full: the new entry replaces main, out_valid stays 1, and no bubble is inserted.
- flush has priority over in/out handshakes in that cycle. Nothing accepted that cycle is retained, and in_ready=1 next cycle.
- Sustained throughput is 1 instruction/clk when out_ready=1.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> one cycle later out_valid=1, a=5, b=7, aluop=0, rd=3, illegal=0.
- SUB 0x40B50533 -> aluop=8. SRAI 0x40315093 with rs1=0x80000000 -> b=3, aluop=13. ADDI x1,x0,-1 (0xFFF00093) -> b=0xFFFFFFFF, aluop=0.
- LUI 0x12345037 -> a=0, b=0x12345000. AUIPC 0x00001097 with pc=0x100 -> a=0x100, b=0x1000, aluop=0.
- Illegal cases -> out_illegal=1, aluop=0, a=b=0:
  - OP with funct7=0100000, funct3=100.
  - SLLI with instr[30]=1.
  - opcode 0000011.
- Backpressure: stream 4 instructions while out_ready=0 -> first two buffered, in_ready=0 from the cycle after the 2nd accept. Then out_ready=1 -> all 4 emerge in order, with no duplicates and no drops.
- flush with both entries full, and separately rst asserted mid-stream -> next cycle out_valid=0 and in_ready=1. The next instruction issued emerges alone.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I OP/OP-IMM/LUI/AUIPC into ALU operands, output registered through a 2-entry skid buffer
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_aluop,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);
  typedef struct packed {
    logic            illegal;
    logic [4:0]      rd;
    logic [3:0]      aluop;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } entry_t;

  entry_t raw, dec, m_q, m_d, s_q, s_d;
  logic m_v_q, m_v_d, s_v_q, s_v_d;
  logic ok, shift, in_fire, out_fire;
  logic [6:0] opc, f7;
  logic [2:0] f3;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign shift = f3 == 3'b001 || f3 == 3'b101;

  always_comb begin
    raw    = '0;
    raw.rd = in_instr[11:7];
    ok     = 1'b0;
    case (opc)
      7'b0110011: begin
        raw.a     = in_rs1;
        raw.b     = in_rs2;
        raw.aluop = {in_instr[30], f3};
        ok        = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      7'b0010011: begin
        raw.a     = in_rs1;
        raw.b     = shift ? {{(XLEN-5){1'b0}}, in_instr[24:20]} : {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        raw.aluop = {f3 == 3'b101 && in_instr[30], f3};
        ok        = !shift || f7 == 7'b0 || (f3 == 3'b101 && f7 == 7'b0100000);
      end
      7'b0110111: begin
        raw.b = {in_instr[31:12], 12'b0};
        ok    = 1'b1;
      end
      7'b0010111: begin
        raw.a = in_pc;
        raw.b = {in_instr[31:12], 12'b0};
        ok    = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    dec = raw;
    if (!ok) begin
      dec         = '0;
      dec.illegal = 1'b1;
      dec.rd      = in_instr[11:7];
    end
  end

  assign in_fire  = in_valid && !s_v_q;
  assign out_fire = out_ready && m_v_q;

  // skid only fills while main is stalled, so it is always empty when in_fire
  always_comb begin
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    m_d   = m_q;
    s_d   = s_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (!m_v_q || out_fire) begin
      m_v_d = s_v_q || in_fire;
      m_d   = s_v_q ? s_q : in_fire ? dec : m_q;
      s_v_d = 1'b0;
    end else if (in_fire) begin
      s_v_d = 1'b1;
      s_d   = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      m_q   <= m_d;
      s_q   <= s_d;
    end
  end

  assign in_ready    = !s_v_q;
  assign out_valid   = m_v_q;
  assign out_a       = m_q.a;
  assign out_b       = m_q.b;
  assign out_aluop   = m_q.aluop;
  assign out_rd      = m_q.rd;
  assign out_illegal = m_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a FIFO-level reference model
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2, out_a, out_b;
  logic [3:0] out_aluop;
  logic [4:0] out_rd;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_aluop(out_aluop), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  logic [31:0] d_instr[9] = '{32'h002081B3, 32'h40B50533, 32'h40315093, 32'hFFF00093, 32'h12345037,
                              32'h00001097, 32'h400042B3, 32'h40001013, 32'h00002083};
  logic [31:0] d_pc[9]    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0};
  logic [31:0] d_rs1[9]   = '{32'd5, 32'd20, 32'h80000000, 32'h0, 32'hDEAD, 32'h55, 32'd9, 32'd9, 32'd9};
  logic [31:0] d_rs2[9]   = '{32'd7, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'd9, 32'd9, 32'd9};
  exp_t d_exp[9] = '{
    '{1'b0, 5'd3, 4'd0, 32'd5, 32'd7},
    '{1'b0, 5'd10, 4'd8, 32'd20, 32'd3},
    '{1'b0, 5'd1, 4'd13, 32'h80000000, 32'd3},
    '{1'b0, 5'd1, 4'd0, 32'h0, 32'hFFFFFFFF},
    '{1'b0, 5'd0, 4'd0, 32'h0, 32'h12345000},
    '{1'b0, 5'd1, 4'd0, 32'h100, 32'h1000},
    '{1'b1, 5'd5, 4'd0, 32'h0, 32'h0},
    '{1'b1, 5'd0, 4'd0, 32'h0, 32'h0},
    '{1'b1, 5'd1, 4'd0, 32'h0, 32'h0}};

  // reference decode by instruction mnemonic
  function automatic exp_t model(input logic [31:0] i, pc, r1, r2);
    exp_t e;
    logic [6:0] f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    e = '0;
    e.rd = i[11:7];
    case (i[6:0])
      7'h33: begin
        e.a = r1;
        e.b = r2;
        if (f7 == 7'h00) e.op = {1'b0, f3};
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd8;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd13;
        else e.ill = 1'b1;
      end
      7'h13: begin
        e.a = r1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {27'd0, i[24:20]};
          if (f7 == 7'h00) e.op = {1'b0, f3};
          else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd13;
          else e.ill = 1'b1;
        end else begin
          e.b = {{20{i[31]}}, i[31:20]};
          e.op = {1'b0, f3};
        end
      end
      7'h37: e.b = {i[31:12], 12'h0};
      7'h17: begin
        e.a = pc;
        e.b = {i[31:12], 12'h0};
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.a = 0;
      e.b = 0;
      e.op = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 9);
    i[6:0] = k < 3 ? 7'h33 : k < 6 ? 7'h13 : k == 6 ? 7'h37 : k == 7 ? 7'h17 : 7'($urandom);
    if ($urandom_range(0, 3) != 0) i[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
    return i;
  endfunction

  function automatic exp_t got();
    return {out_illegal, out_rd, out_aluop, out_a, out_b};
  endfunction

  task automatic drive_rand(output exp_t e);
    in_instr = rand_instr();
    in_pc = $urandom;
    in_rs1 = $urandom;
    in_rs2 = $urandom;
    in_valid = 1'b1;
    e = model(in_instr, in_pc, in_rs1, in_rs2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    in_pc = 0;
    in_rs1 = 1;
    in_rs2 = 2;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (got() !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", got()); end
  endtask

  task automatic test_decode();
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 49; k++) begin
      @(negedge clk);
      if (k < 9) begin
        in_instr = d_instr[k];
        in_pc = d_pc[k];
        in_rs1 = d_rs1[k];
        in_rs2 = d_rs2[k];
        in_valid = 1'b1;
        e = d_exp[k];
      end else drive_rand(e);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL decode_valid[%0d] instr %h got %b exp 1", k, in_instr, out_valid); end
      checks++; if (got() !== e) begin errors++; $display("FAIL decode_data[%0d] instr %h got %h exp %h", k, in_instr, got(), e); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL decode_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    exp_t e[4];
    out_ready = 1'b0;
    @(negedge clk); drive_rand(e[0]);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b1 || got() !== e[0]) begin errors++; $display("FAIL bp_head0 got %b/%h exp 1/%h", out_valid, got(), e[0]); end
    drive_rand(e[1]);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b exp 0", in_ready); end
    checks++; if (got() !== e[0]) begin errors++; $display("FAIL bp_hold0 got %h exp %h", got(), e[0]); end
    drive_rand(e[2]);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", in_ready); end
    checks++; if (got() !== e[0]) begin errors++; $display("FAIL bp_stable0 got %h exp %h", got(), e[0]); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b exp 1", in_ready); end
    checks++; if (got() !== e[1]) begin errors++; $display("FAIL bp_out1 got %h exp %h", got(), e[1]); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || got() !== e[2]) begin errors++; $display("FAIL bp_out2 got %b/%h exp 1/%h", out_valid, got(), e[2]); end
    drive_rand(e[3]);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || got() !== e[3]) begin errors++; $display("FAIL bp_out3 got %b/%h exp 1/%h", out_valid, got(), e[3]); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_discard(input bit use_rst);
    exp_t e;
    out_ready = 1'b0;
    @(negedge clk); drive_rand(e);
    @(negedge clk); drive_rand(e);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL discard_full[%0d] got %b exp 0", use_rst, in_ready); end
    drive_rand(e);
    out_ready = 1'b1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL discard_state[%0d] got valid %b ready %b exp 0 1", use_rst, out_valid, in_ready); end
    if (use_rst) begin
      checks++; if (got() !== '0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", got()); end
    end
    drive_rand(e);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || got() !== e) begin errors++; $display("FAIL discard_next[%0d] got %b/%h exp 1/%h", use_rst, out_valid, got(), e); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL discard_alone[%0d] got %b exp 0", use_rst, out_valid); end
  endtask

  task automatic test_random_stream();
    exp_t q[$];
    exp_t e;
    bit of, inf;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, in_ready, q.size() < 2); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (got() !== q[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", c, got(), q[0]); end
      end
      drive_rand(e);
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) == 0;
      flush = $urandom_range(0, 19) == 0;
      of = out_ready && q.size() != 0;
      inf = in_valid && q.size() < 2;
      if (flush) q.delete();
      else begin
        if (of) void'(q.pop_front());
        if (inf) q.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_discard(1'b0);
    test_discard(1'b1);
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
